screen_sequencer: RTL

//  Game-flow controller that produces the 4-bit screen select code and blink flag consumed by the VGA output mux.

---
 rtl/screen_sequencer_if.sv | 25 ++
 rtl/screen_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/screen_sequencer_if.sv
// Button/event pulses into the screen sequencer and screen-select outputs toward the VGA mux.
// master = stimulus/controller side, slave = sequencer side.
interface screen_sequencer_if;
    logic       btn_start;
    logic       btn_nav;
    logic       btn_ok;
    logic       btn_back;
    logic       game_win;
    logic       game_lose;
    logic [3:0] vga_control;
    logic       blink;
    logic       menu_sel;
    logic       game_en;
    logic       game_rst;

    modport master (
        output btn_start, btn_nav, btn_ok, btn_back, game_win, game_lose,
        input  vga_control, blink, menu_sel, game_en, game_rst
    );

    modport slave (
        input  btn_start, btn_nav, btn_ok, btn_back, game_win, game_lose,
        output vga_control, blink, menu_sel, game_en, game_rst
    );
endinterface

// File: rtl/screen_sequencer.sv
// Game-flow FSM: power-up -> intro -> menu -> tutorial/stage -> win/lose, driving the VGA screen code.
// Latency: inputs sampled on a cycle are reflected on outputs after the next clk edge (all outputs registered).
// Backpressure: none; every input is a one-cycle pulse and is either consumed or ignored in the cycle it arrives.
module screen_sequencer #(
    parameter int POWERUP_CYC = 100,
    parameter int BLINK_HALF  = 50_000_000,
    parameter int RESULT_CYC  = 300_000_000,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               clr,
    screen_sequencer_if.slave  bus
);

    typedef enum logic [3:0] {
        S_OFF      = 4'd0,
        S_INTRO    = 4'd1,
        S_MENU     = 4'd2,
        S_TUTORIAL = 4'd3,
        S_STAGE    = 4'd4,
        S_WIN      = 4'd5,
        S_LOSE     = 4'd6
    } state_t;

    localparam logic [CNT_W-1:0] POWERUP_LAST = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST   = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] RESULT_LAST  = CNT_W'(RESULT_CYC - 1);

    state_t           state_q;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer_q;
    logic [CNT_W-1:0] timer_nxt;
    logic             blink_q;
    logic             blink_nxt;
    logic             menu_sel_q;
    logic             menu_sel_nxt;
    logic             game_en_q;
    logic             game_en_nxt;
    logic             game_rst_q;
    logic             game_rst_nxt;
    logic             state_chg;
    logic             blink_wrap;

    // State, shared timer and every output live in one register bank so clr clears them together.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_OFF;
            timer_q    <= '0;
            blink_q    <= 1'b0;
            menu_sel_q <= 1'b0;
            game_en_q  <= 1'b0;
            game_rst_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            timer_q    <= timer_nxt;
            blink_q    <= blink_nxt;
            menu_sel_q <= menu_sel_nxt;
            game_en_q  <= game_en_nxt;
            game_rst_q <= game_rst_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_OFF: begin
                if (timer_q == POWERUP_LAST) state_nxt = S_INTRO;
            end
            S_INTRO: begin
                if (bus.btn_start) state_nxt = S_MENU;
            end
            S_MENU: begin
                // Confirm uses the cursor as it stood before any same-cycle nav pulse.
                if (bus.btn_ok) state_nxt = menu_sel_q ? S_TUTORIAL : S_STAGE;
            end
            S_TUTORIAL: begin
                if (bus.btn_ok || bus.btn_back) state_nxt = S_MENU;
            end
            S_STAGE: begin
                if (bus.game_lose)     state_nxt = S_LOSE;
                else if (bus.game_win) state_nxt = S_WIN;
            end
            S_WIN, S_LOSE: begin
                if (bus.btn_ok || timer_q == RESULT_LAST) state_nxt = S_MENU;
            end
            default: state_nxt = S_OFF;
        endcase
    end

    assign state_chg  = (state_nxt != state_q);
    assign blink_wrap = (state_q == S_INTRO) && (timer_q == BLINK_LAST);

    always_comb begin
        timer_nxt    = timer_q;
        blink_nxt    = blink_q;
        menu_sel_nxt = menu_sel_q;
        game_en_nxt  = 1'b0;
        game_rst_nxt = 1'b0;

        if (state_chg || blink_wrap) begin
            timer_nxt = '0;
        end else if (!(&timer_q)) begin
            timer_nxt = timer_q + 1'b1;
        end

        // Blink only ever runs inside INTRO; leaving INTRO forces it low on the same edge.
        if (state_nxt != S_INTRO) begin
            blink_nxt = 1'b0;
        end else if (blink_wrap) begin
            blink_nxt = ~blink_q;
        end

        if (state_q == S_MENU && bus.btn_nav && !bus.btn_ok) begin
            menu_sel_nxt = ~menu_sel_q;
        end

        if (state_nxt == S_STAGE) begin
            game_en_nxt  = 1'b1;
            game_rst_nxt = (state_q != S_STAGE);
        end
    end

    assign bus.vga_control = state_q;
    assign bus.blink       = blink_q;
    assign bus.menu_sel    = menu_sel_q;
    assign bus.game_en     = game_en_q;
    assign bus.game_rst    = game_rst_q;

endmodule
